dmem_ctrl: RTL and testbench

- MEM-stage data-memory access controller for the RV32I pipeline.
- Accepts one load/store per instruction, generates byte enables and a lane-replicated store word, and holds the request on the data-memory port until `mem_resp`.
- Stalls the pipeline during the access and registers the raw read word for the WB stage's byte/half extraction.
- Detects misaligned accesses and flags a watchdog timeout.

---
 rtl/dmem_ctrl_pkg.sv | 65 ++++++
 rtl/dmem_ctrl_if.sv | 35 +++
 rtl/dmem_ctrl_lane_gen.sv | 40 ++++
 rtl/dmem_ctrl.sv | 143 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared RV32I types for the MEM-stage data-memory controller: opcodes,
// load/store funct3 encodings, controller states and access-width decode.
package dmem_ctrl_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } dmem_state_t;

    typedef enum logic [1:0] {
        W_BYTE = 2'b00,
        W_HALF = 2'b01,
        W_WORD = 2'b10
    } access_width_t;

    // Unrecognised funct3 encodings fall back to a full-word access.
    function automatic access_width_t decode_width(input logic is_store,
                                                   input logic [2:0] funct3);
        access_width_t w;
        w = W_WORD;
        if (is_store) begin
            case (funct3)
                sb:      w = W_BYTE;
                sh:      w = W_HALF;
                default: w = W_WORD;
            endcase
        end else begin
            case (funct3)
                lb, lbu: w = W_BYTE;
                lh, lhu: w = W_HALF;
                default: w = W_WORD;
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Pipeline-side and memory-side signals of the data-memory controller.
interface dmem_ctrl_if;
    import dmem_ctrl_pkg::*;

    logic        req_valid;
    rv32i_opcode opcode;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        stall;
    logic [31:0] rdata_buf;
    logic        misalign_err;
    logic        timeout_err;

    modport slave (
        input  req_valid, opcode, funct3, addr, store_data, mem_rdata, mem_resp,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
               stall, rdata_buf, misalign_err, timeout_err
    );

    modport master (
        output req_valid, opcode, funct3, addr, store_data, mem_rdata, mem_resp,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
               stall, rdata_buf, misalign_err, timeout_err
    );

endinterface

// File: rtl/dmem_ctrl_lane_gen.sv
// Combinational lane logic: byte enables, lane-replicated store data and
// the alignment check for one load/store.
module dmem_lane_gen
    import dmem_ctrl_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned
);

    access_width_t width;

    always_comb begin
        width      = decode_width(is_store, funct3);
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = 1'b0;
        case (width)
            W_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            W_HALF: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata      = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
        // Loads always fetch the full word; WB extracts the lane.
        if (!is_store) be = 4'b1111;
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory access controller: issues one load/store, holds it
// until mem_resp, stalls the pipeline and captures the read word for WB.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    dmem_ctrl_if.slave bus
);

    // state  | meaning
    // IDLE   | waiting for a valid load/store from MEM
    // ACCESS | request held on the memory port until mem_resp or watchdog
    // DONE   | one unstalled cycle so the pipeline advances past the access

    dmem_state_t state_q, state_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;
    logic [31:0] wd_cnt_q, wd_cnt_d;

    logic        is_ldst;
    logic        is_store;
    logic        accept;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        lane_misaligned;

    assign is_ldst  = (bus.opcode == op_load) || (bus.opcode == op_store);
    assign is_store = (bus.opcode == op_store);
    assign accept   = (state_q == IDLE) && bus.req_valid && is_ldst;

    dmem_lane_gen u_lane_gen (
        .is_store   (is_store),
        .funct3     (bus.funct3),
        .addr_lo    (bus.addr[1:0]),
        .store_data (bus.store_data),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .misaligned (lane_misaligned)
    );

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rdata_d     = rdata_q;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;
        wd_cnt_d    = wd_cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (lane_misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        mem_read_d  = !is_store;
                        mem_write_d = is_store;
                        addr_d      = {bus.addr[31:2], 2'b00};
                        wdata_d     = lane_wdata;
                        be_d        = lane_be;
                        wd_cnt_d    = '0;
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_resp) begin
                    state_d     = DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_read_q) rdata_d = bus.mem_rdata;
                end else begin
                    wd_cnt_d = wd_cnt_q + 32'd1;
                    // A response arriving on the final cycle takes the branch above.
                    if ((TIMEOUT_CYCLES != 0) && (wd_cnt_d == TIMEOUT_CYCLES)) begin
                        state_d     = DONE;
                        mem_read_d  = 1'b0;
                        mem_write_d = 1'b0;
                        timeout_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
            wd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    // The accept cycle stalls before the FSM has left IDLE.
    assign bus.stall           = (accept && !lane_misaligned) || (state_q == ACCESS);
    assign bus.mem_read        = mem_read_q;
    assign bus.mem_write       = mem_write_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_wdata       = wdata_q;
    assign bus.mem_byte_enable = be_q;
    assign bus.rdata_buf       = rdata_q;
    assign bus.misalign_err    = misalign_q;
    assign bus.timeout_err     = timeout_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed plus randomized bench for dmem_ctrl with a 4-cycle watchdog.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_ctrl_if bus();

    dmem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int txn_cnt  = 0;
    logic req_prev = 1'b0;
    logic [31:0] m_rdata_buf = 32'h0;

    // Counts memory transactions as rising edges of the request.
    always @(negedge clk) begin
        if ((bus.mem_read || bus.mem_write) && !req_prev) txn_cnt++;
        req_prev = bus.mem_read || bus.mem_write;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int unsigned exp_size(input bit st, input logic [2:0] f3);
        if (st) begin
            if (f3 == 3'd0) return 1;
            if (f3 == 3'd1) return 2;
            return 4;
        end
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] exp_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        int unsigned m;
        if (!st) return 4'hF;
        sz = exp_size(st, f3);
        m  = ((32'd1 << sz) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input bit st, input logic [2:0] f3, input logic [31:0] d);
        int unsigned sz;
        sz = exp_size(st, f3);
        if (sz == 1) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, input int wait_n, input logic [31:0] rd,
                             input bit hold_req, input string tag);
        int unsigned sz;
        bit mis;
        bit to_exp;
        int n_acc;
        sz  = exp_size(st, f3);
        mis = (a % sz) != 0;

        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.opcode     = st ? op_store : op_load;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.store_data = d;
        bus.mem_resp   = 1'b0;
        @(negedge clk);
        chk1({tag, "_accept_stall"}, bus.stall, !mis);
        chk({tag, "_accept_rbuf"}, bus.rdata_buf, m_rdata_buf);

        if (mis) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            @(negedge clk);
            chk1({tag, "_mis_err"}, bus.misalign_err, 1'b1);
            chk1({tag, "_mis_noreq"}, bus.mem_read || bus.mem_write, 1'b0);
            chk1({tag, "_mis_stall"}, bus.stall, 1'b0);
            @(posedge clk); #1;
            @(negedge clk);
            chk1({tag, "_mis_pulse_end"}, bus.misalign_err, 1'b0);
            chk1({tag, "_mis_noreq2"}, bus.mem_read || bus.mem_write, 1'b0);
            return;
        end

        to_exp = (wait_n > int'(TO));
        n_acc  = to_exp ? int'(TO) : wait_n;
        for (int k = 1; k <= n_acc; k++) begin
            @(posedge clk); #1;
            if (!hold_req) bus.req_valid = 1'b0;
            bus.mem_resp  = (k == wait_n);
            bus.mem_rdata = rd;
            @(negedge clk);
            chk1({tag, "_acc_read"}, bus.mem_read, !st);
            chk1({tag, "_acc_write"}, bus.mem_write, st);
            chk({tag, "_acc_addr"}, bus.mem_address, a & 32'hFFFF_FFFC);
            chk({tag, "_acc_be"}, 32'(bus.mem_byte_enable), 32'(exp_be(st, f3, a)));
            if (st) chk({tag, "_acc_wdata"}, bus.mem_wdata, exp_wdata(st, f3, d));
            chk1({tag, "_acc_stall"}, bus.stall, 1'b1);
            chk1({tag, "_acc_to"}, bus.timeout_err, 1'b0);
        end
        if (!st && !to_exp) m_rdata_buf = rd;

        // DONE cycle, with a possible spurious response that must be ignored.
        @(posedge clk); #1;
        if (!hold_req) bus.req_valid = 1'b0;
        bus.mem_resp  = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        @(negedge clk);
        chk1({tag, "_done_stall"}, bus.stall, 1'b0);
        chk1({tag, "_done_noreq"}, bus.mem_read || bus.mem_write, 1'b0);
        chk1({tag, "_done_to"}, bus.timeout_err, to_exp);
        chk({tag, "_done_rbuf"}, bus.rdata_buf, m_rdata_buf);
    endtask

    task automatic do_ignored(input rv32i_opcode op, input logic rv, input logic [2:0] f3,
                              input logic [31:0] a);
        @(posedge clk); #1;
        bus.req_valid = rv;
        bus.opcode    = op;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.mem_resp  = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        @(negedge clk);
        chk1("ign_stall", bus.stall, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.mem_resp  = 1'b0;
        @(negedge clk);
        chk1("ign_noreq", bus.mem_read || bus.mem_write, 1'b0);
        chk1("ign_mis", bus.misalign_err, 1'b0);
        chk("ign_rbuf", bus.rdata_buf, m_rdata_buf);
    endtask

    initial begin
        rv32i_opcode others [4];
        int t0;
        others = '{op_lui, op_jal, op_imm, op_reg};

        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.opcode     = op_imm;
        bus.funct3     = 3'd0;
        bus.addr       = 32'h0;
        bus.store_data = 32'h0;
        bus.mem_rdata  = 32'h0;
        bus.mem_resp   = 1'b0;
        #1;
        chk1("rst_read", bus.mem_read, 1'b0);
        chk1("rst_write", bus.mem_write, 1'b0);
        chk("rst_addr", bus.mem_address, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_be", 32'(bus.mem_byte_enable), 32'h0);
        chk1("rst_stall", bus.stall, 1'b0);
        chk("rst_rbuf", bus.rdata_buf, 32'h0);
        chk1("rst_mis", bus.misalign_err, 1'b0);
        chk1("rst_to", bus.timeout_err, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_access(1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0, "lw100");
        do_access(1'b1, 3'b000, 32'h203, 32'hA5, 1, 32'h11111111, 1'b0, "sb203");
        chk("sb_rbuf_kept", bus.rdata_buf, 32'hDEADBEEF);
        do_access(1'b1, 3'b001, 32'h302, 32'h1234, 2, 32'h22222222, 1'b0, "sh302");
        do_access(1'b0, 3'b001, 32'h301, 32'h0, 1, 32'h33333333, 1'b0, "lh301");
        do_access(1'b0, 3'b010, 32'h400, 32'h0, 1000, 32'h44444444, 1'b0, "lw_timeout");
        do_access(1'b0, 3'b010, 32'h404, 32'h0, 4, 32'h55AA55AA, 1'b0, "lw_resp4");

        // Reset in the second ACCESS cycle, then a late response.
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.opcode    = op_load;
        bus.funct3    = 3'b010;
        bus.addr      = 32'h40;
        bus.mem_resp  = 1'b0;
        @(negedge clk);
        chk1("rstmid_accept", bus.stall, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk1("rstmid_acc1", bus.mem_read, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        m_rdata_buf = 32'h0;
        chk1("rstmid_read", bus.mem_read, 1'b0);
        chk1("rstmid_stall", bus.stall, 1'b0);
        chk("rstmid_addr", bus.mem_address, 32'h0);
        chk("rstmid_be", 32'(bus.mem_byte_enable), 32'h0);
        chk("rstmid_rbuf", bus.rdata_buf, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk1("late_read", bus.mem_read, 1'b0);
        chk1("late_stall", bus.stall, 1'b0);
        @(posedge clk); #1;
        bus.mem_resp = 1'b0;
        @(negedge clk);
        chk("late_rbuf", bus.rdata_buf, 32'h0);
        chk1("late_read2", bus.mem_read, 1'b0);

        // Back-to-back with req_valid held high.
        t0 = txn_cnt;
        do_access(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h0BADCAFE, 1'b1, "b2b_lw");
        do_access(1'b1, 3'b010, 32'h14, 32'h89ABCDEF, 2, 32'h0, 1'b1, "b2b_sw");
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.mem_resp  = 1'b0;
        @(negedge clk);
        chk1("b2b_idle_stall", bus.stall, 1'b0);
        chk("b2b_txn_count", 32'(txn_cnt - t0), 32'd2);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                if ($urandom_range(0, 1) == 0)
                    do_ignored(others[$urandom_range(0, 3)], 1'b1, 3'($urandom), $urandom);
                else
                    do_ignored(op_load, 1'b0, 3'($urandom), $urandom);
            end else begin
                do_access(1'($urandom), 3'($urandom), $urandom, $urandom,
                          int'($urandom_range(1, 6)), $urandom, 1'b0, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
